// File: rtl/philv_load_store_unit.sv
// philv_load_store_unit
// Memory-stage load/store unit for the Philosophy-V core. Takes one RV32I
// load or store from the execute stage and turns it into a single
// word-aligned, byte-enabled access on a req/ack data-memory port. Load data
// is aligned and sign/zero-extended. The pipeline is stalled until the
// access completes.
//
// Optional feature (macro LSU_TIMEOUT_EN): abort an access that sees no
// mem_ack within TIMEOUT_CYCLES cycles of REQ and report it as an error.
// Without the macro, REQ waits indefinitely for mem_ack.
//
// Ports:
//   clk, rstb             core clock, synchronous active-low reset
//   req_valid/req_ready   execute-stage handshake (ready only in IDLE)
//   req_we, req_funct3    store flag and RV32I funct3
//   req_addr, req_wdata   byte address and store data (rs2)
//   resp_valid/resp_err   one-cycle completion pulse, error flag
//   resp_rdata            extended load data (0 for stores and errors)
//   stall                 pipeline hold request
//   mem_req/mem_ack       memory request, held until ack
//   mem_we, mem_addr      write strobe, word address
//   mem_be, mem_wdata     byte enables, lane-replicated store data
//   mem_rdata             read word, valid with mem_ack
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a new op; req_valid sampled every cycle
// REQ   | mem_req held with stable address/enables/data until mem_ack
// RESP  | resp_valid pulse; pipeline advances, back to IDLE next cycle

module philv_load_store_unit #(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic                 resp_err,
    output logic [BUS_WIDTH-1:0] resp_rdata,
    output logic                 stall,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [3:0]           mem_be,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] lat_funct3;
    logic [1:0] lat_lo;

    // Request decode (access size: 0 byte, 1 halfword, 2 word)
    logic [1:0]           size;
    logic                 illegal;
    logic                 misaligned;
    logic [3:0]           be_new;
    logic [BUS_WIDTH-1:0] wdata_new;

    always_comb begin
        size    = 2'd0;
        illegal = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: size = 2'd0;
            3'b001, 3'b101: size = 2'd1;
            3'b010:         size = 2'd2;
            default:        illegal = 1'b1;
        endcase
        // Stores have no unsigned variants, so funct3[2] set is illegal.
        if (req_we && req_funct3[2])
            illegal = 1'b1;

        misaligned = ((size == 2'd1) && req_addr[0]) ||
                     ((size == 2'd2) && (req_addr[1:0] != 2'b00));

        case (size)
            2'd0: begin
                be_new    = 4'b0001 << req_addr[1:0];
                wdata_new = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                be_new    = 4'b0011 << req_addr[1:0];
                wdata_new = {2{req_wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = req_wdata;
            end
        endcase
    end

    // Load alignment uses only the values latched at acceptance.
    logic [BUS_WIDTH-1:0] rdata_shifted;
    logic [BUS_WIDTH-1:0] load_data;

    assign rdata_shifted = mem_rdata >> {lat_lo, 3'b000};

    always_comb begin
        case (lat_funct3)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b100:  load_data = {24'd0, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b101:  load_data = {16'd0, rdata_shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
    end

    logic timeout;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Counts completed REQ cycles; the abort fires on the cycle whose edge
    // would bring the count to TIMEOUT_CYCLES.
    always_ff @(posedge clk) begin
        if (!rstb)
            tmo_cnt <= '0;
        else if (state != REQ)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'b0000;
            mem_wdata  <= '0;
            lat_funct3 <= 3'b000;
            lat_lo     <= 2'b00;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (illegal || misaligned) begin
                            // Rejected ops never touch the memory port.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state      <= REQ;
                            mem_req    <= 1'b1;
                            mem_we     <= req_we;
                            mem_addr   <= {req_addr[BUS_WIDTH-1:2], 2'b00};
                            mem_be     <= be_new;
                            mem_wdata  <= wdata_new;
                            lat_funct3 <= req_funct3;
                            lat_lo     <= req_addr[1:0];
                        end
                    end
                end
                REQ: begin
                    // An ack arriving together with the timeout still wins.
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= mem_we ? '0 : load_data;
                    end else if (timeout) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

    // Low in RESP so the pipeline advances on the cycle resp_rdata is valid.
    assign stall = (state == REQ) || ((state == IDLE) && req_valid);

endmodule

// File: tb/tb_philv_load_store_unit.sv
module tb_philv_load_store_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rstb;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    philv_load_store_unit #(
        .BUS_WIDTH      (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rstb       (rstb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_bytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int n = ref_bytes(f3);
        if (n == 0) return 1'b1;
        if (we && f3 > 3'd2) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int n = ref_bytes(f3);
        int m = ((1 << n) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = ref_bytes(f3);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = wd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int n = ref_bytes(f3);
        logic [63:0] v;
        logic [63:0] rd64;
        rd64 = {32'd0, rd};
        v = (rd64 >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 64'd1);
        if (!f3[2] && v[8*n-1])
            v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    // Issue one op starting just after a rising edge; ack after 'waits' stall cycles.
    task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input logic [31:0] rd,
                         input string tag);
        bit err = ref_err(we, f3, a);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        check_val({tag, ".ready"}, req_ready, 1);
        check_val({tag, ".stall_acc"}, stall, 1);
        @(posedge clk); #1;
        // Scramble the request: only the latched values may matter now.
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_valid  = 1'($urandom_range(0, 1));
        if (!err) begin
            for (int c = 0; c <= waits; c++) begin
                @(negedge clk);
                check_val({tag, ".mem_req"}, mem_req, 1);
                check_val({tag, ".stall_req"}, stall, 1);
                check_val({tag, ".early_resp"}, resp_valid, 0);
                check_val({tag, ".mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
                check_val({tag, ".mem_be"}, mem_be, ref_be(f3, a));
                check_val({tag, ".mem_we"}, mem_we, we);
                if (we) check_val({tag, ".mem_wdata"}, mem_wdata, ref_wdata(f3, wd));
                mem_ack   = (c == waits);
                mem_rdata = (c == waits) ? rd : $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        @(negedge clk);
        check_val({tag, ".resp_valid"}, resp_valid, 1);
        check_val({tag, ".resp_err"}, resp_err, err);
        check_val({tag, ".resp_rdata"}, resp_rdata, (err || we) ? 32'd0 : ref_load(f3, a, rd));
        check_val({tag, ".stall_resp"}, stall, 0);
        check_val({tag, ".mem_req_resp"}, mem_req, 0);
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [2:0] legal_f3 [8];
    int         tmo_cnt;

    initial begin
        legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4;
        legal_f3[4] = 3'd5; legal_f3[5] = 3'd3; legal_f3[6] = 3'd6; legal_f3[7] = 3'd7;

        rstb = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst.req_ready", req_ready, 1);
        check_val("rst.mem_req", mem_req, 0);
        check_val("rst.resp_valid", resp_valid, 0);
        check_val("rst.resp_err", resp_err, 0);
        check_val("rst.resp_rdata", resp_rdata, 0);
        check_val("rst.mem_addr", mem_addr, 0);
        check_val("rst.mem_be", mem_be, 0);
        check_val("rst.mem_wdata", mem_wdata, 0);
        check_val("rst.mem_we", mem_we, 0);
        check_val("rst.stall", stall, 0);
        rstb = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, "lw100");
        do_op(1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80123456, "lb103");
        do_op(1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h80123456, "lbu103");
        do_op(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 3, 32'h0, "sh202");
        do_op(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0, "lw101");
        do_op(1'b1, 3'd3, 32'h200, 32'h55, 0, 32'h0, "st011");
        do_op(1'b0, 3'd5, 32'h302, 32'h0, 2, 32'h9ABC1234, "lhu302");
        do_op(1'b0, 3'd1, 32'h302, 32'h0, 0, 32'h9ABC1234, "lh302");

        // Reset mid-REQ: no response, late ack ignored
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h400;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_val("rstreq.mem_req_before", mem_req, 1);
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        @(negedge clk);
        check_val("rstreq.mem_req", mem_req, 0);
        check_val("rstreq.req_ready", req_ready, 1);
        check_val("rstreq.resp_valid", resp_valid, 0);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_val("rstreq.late_ack", resp_valid, 0);
        check_val("rstreq.mem_req_after", mem_req, 0);
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tmo_cnt = 0;
        while (tmo_cnt < 3 * TMO) begin
            @(negedge clk);
            if (!mem_req) break;
            tmo_cnt++;
        end
        check_val("tmo.req_cycles", tmo_cnt, TMO);
        check_val("tmo.resp_valid", resp_valid, 1);
        check_val("tmo.resp_err", resp_err, 1);
        check_val("tmo.resp_rdata", resp_rdata, 0);
        @(posedge clk); #1;
`endif

        // Randomized ops, with stray acks in idle gaps
        for (int i = 0; i < 300; i++) begin
            bit          we = 1'($urandom_range(0, 1));
            logic [2:0]  f3 = legal_f3[$urandom_range(0, 7)];
            logic [31:0] a  = $urandom;
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1; mem_rdata = $urandom;
                @(negedge clk);
                check_val("idle.mem_req", mem_req, 0);
                @(posedge clk); #1;
                mem_ack = 1'b0;
                @(negedge clk);
                check_val("idle.stray_ack", resp_valid, 0);
                check_val("idle.ready", req_ready, 1);
                @(posedge clk); #1;
            end
            do_op(we, f3, a, $urandom, $urandom_range(0, 5), $urandom, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/philv_load_store_unit.md
# philv_load_store_unit

Memory-stage load/store unit for the Philosophy-V core. Sits between the execute-stage register and the memory-stage register. Converts one RV32I load or store per request into a word-aligned, byte-enabled access on a simple req/ack data-memory port. Aligns and sign- or zero-extends load data, and stalls the pipeline until the access completes.

## Interface
- BUS_WIDTH, 32, data and address width (only 32 supported)
- TIMEOUT_CYCLES, 16, cycles in REQ without ack before abort (used only with LSU_TIMEOUT_EN)
- clk  in  1  core clock; all state changes on rising edge
- rstb  in  1  reset, **synchronous, active-low**
- req_valid  in  1  execute stage presents a memory op
- req_ready  out  1  LSU can accept (state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle pulse: op finished
- resp_err  out  1  valid with resp_valid: misaligned, illegal funct3 or timeout
- resp_rdata  out  32  extended load data; 0 for stores and errors
- stall  out  1  pipeline hold request
- mem_req  out  1  memory access request, held until ack
- mem_we  out  1  write strobe
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  access complete; mem_rdata valid this cycle
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**, req_valid=1, legal and aligned:
  - latch we, funct3, addr[1:0], mem_addr, mem_be and mem_wdata
  - go to REQ
- **IDLE**, req_valid=1, misaligned or illegal:
  - go to RESP with the error flag set
  - no mem_req is issued
- **REQ**: mem_req=1 with stable outputs. On mem_ack, capture mem_rdata and go to RESP.
- **RESP**: resp_valid=1 for one cycle, then go to IDLE.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
- Illegal: funct3 ∈ {011,110,111}; store funct3 ≥ 011.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0]
  - SH/LH/LHU: 4'b0011<<addr[1:0]
  - SW/LW: 4'b1111
- Store data replication:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load data: the selected byte or halfword is shifted to bit 0. LB/LH sign-extend; LBU/LHU zero-extend.
- stall = (state==REQ) | (state==IDLE & req_valid). It is low in RESP so the pipeline advances with resp_rdata.
- mem_ack outside REQ is ignored.

## Timing
- Reset (rstb=0 at an edge): state goes to IDLE.
  - All outputs return to 0 except req_ready=1.
  - mem_addr, mem_be, mem_wdata and resp_rdata clear to 0.
- Latency, with accept at edge 0:
  - mem_req is high in cycle 1.
  - With ack in cycle 1, resp_valid is high in cycle 2.
  - Each added ack wait cycle adds 1.
- Error path: resp_valid and resp_err are high the cycle after acceptance.
- The request must not change while stall=1. The LSU uses only the values latched at acceptance.
- req_valid during REQ or RESP is not accepted. It is sampled again once the state returns to IDLE.
- Back-to-back throughput: one op per 3 cycles with zero-wait memory.
- Reset mid-REQ: mem_req drops after the reset edge. No response is produced, and a late mem_ack is ignored.

## Configuration
- **LSU_TIMEOUT_EN** defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to REQ and increments each REQ cycle.
  - When it reaches TIMEOUT_CYCLES without ack: drop mem_req and go to RESP with resp_err=1 and resp_rdata=0.
  - An ack in the same cycle as the timeout wins, and the op completes normally.
- Not defined: no counter is built, and REQ waits indefinitely for mem_ack.

## Test plan
- LW at 0x100, ack in the same cycle as mem_req, mem_rdata=0xDEADBEEF:
  - mem_addr=0x100, mem_be=1111
  - resp_rdata=0xDEADBEEF, resp_valid exactly 2 cycles after accept
- LB at 0x103, mem_rdata=0x80123456 → resp_rdata=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202, wdata=0x1234ABCD, 3 wait cycles → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, stall high for 5 cycles.
- LW at 0x101 → no mem_req, resp_valid=resp_err=1 next cycle, resp_rdata=0. Store with funct3=011 → same response.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack → mem_req drops after 16 REQ cycles, resp_err=1.
- Reset mid-REQ:
  - rstb=0 for one edge during REQ → mem_req=0, req_ready=1
  - a following mem_ack produces no resp_valid
